// File: rtl/titan_hazard_scoreboard.sv
// titan_hazard_scoreboard
//   Per-register result-latency scoreboard for an in-order pipeline. Each
//   architectural register r != 0 keeps a countdown of cycles until its
//   pending result becomes forwardable. ID sources are checked against those
//   counts: counts above FWD_WIN stall, counts 1..FWD_WIN forward.
//   A trap seen in ID stalls the front end, waits for all in-flight results
//   to drain, then issues a one-cycle flush pulse.
//
// Handshake: the ID instruction is consumed (issues) in a cycle where
//   id_valid_i=1 and stall_o=0 and no trap is being taken. While stall_o=1
//   the ID stage must hold its instruction and inputs stable.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   id_valid_i           valid instruction in ID
//   id_rs_i              NUM_SRC source indices, port k at [k*AW +: AW]
//   id_rs_used_i         per-port source-used flag
//   id_rd_i, id_rd_we_i  destination register and its write enable
//   id_lat_i             result latency (clamped to MAX_LAT)
//   id_trap_i            trap condition detected in ID
//   hz_stall_o           data-hazard stall
//   trap_stall_o         trap-drain stall
//   stall_o              hz_stall_o | trap_stall_o
//   fwd_en_o             per-port forwarding enable
//   flush_o              one-cycle flush pulse
//   busy_o               any counter nonzero
module titan_hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 4,
  parameter int FWD_WIN  = 1,
  localparam int LW = $clog2(MAX_LAT + 1),
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [NUM_SRC*AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]    id_rs_used_i,
  input  logic [AW-1:0]         id_rd_i,
  input  logic                  id_rd_we_i,
  input  logic [LW-1:0]         id_lat_i,
  input  logic                  id_trap_i,
  output logic                  hz_stall_o,
  output logic                  trap_stall_o,
  output logic                  stall_o,
  output logic [NUM_SRC-1:0]    fwd_en_o,
  output logic                  flush_o,
  output logic                  busy_o
);

  localparam logic [LW-1:0] FWD_W = LW'(FWD_WIN);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q [NUM_REGS];
  logic [LW-1:0]   cnt_d [NUM_REGS];

  logic [AW-1:0]   rs_idx  [NUM_SRC];
  logic [LW-1:0]   src_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] hz_vec;
  logic [NUM_SRC-1:0] fwd_raw;
  logic            trap_accept;
  logic            issue;
  logic [LW-1:0]   lat_c;
  logic [LW-1:0]   rd_dec;

  // Busy: any tracked register still has a pending result.
  always_comb begin
    busy_o = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) busy_o = 1'b1;
    end
  end

  // Source checks use the pre-issue counts, so a source that equals the
  // same instruction's rd sees the older producer, not itself.
  always_comb begin
    hz_vec  = '0;
    fwd_raw = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs_idx[k]  = id_rs_i[k*AW +: AW];
      src_cnt[k] = '0;
      if (rs_idx[k] != '0) src_cnt[k] = cnt_q[rs_idx[k]];
      if (id_rs_used_i[k] && (src_cnt[k] > FWD_W)) hz_vec[k] = id_valid_i;
      if (id_rs_used_i[k] && (src_cnt[k] != '0) && (src_cnt[k] <= FWD_W)) fwd_raw[k] = 1'b1;
    end
  end

  assign trap_accept  = (state_q == ST_IDLE) && id_valid_i && id_trap_i;
  assign hz_stall_o   = |hz_vec;
  assign trap_stall_o = (state_q != ST_IDLE) || trap_accept;
  assign stall_o      = hz_stall_o || trap_stall_o;
  assign fwd_en_o     = stall_o ? '0 : fwd_raw;
  assign flush_o      = (state_q == ST_FLUSH);
  assign issue        = id_valid_i && !stall_o && (state_q == ST_IDLE) && !id_trap_i;

  // Trap FSM: DRAIN waits for all counters to reach zero, then one FLUSH cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (id_valid_i && id_trap_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!busy_o) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters: saturating decrement; a new writer keeps the larger of its
  // clamped latency and the already-decremented older count (WAW safety).
  always_comb begin
    lat_c  = (id_lat_i > MAX_L) ? MAX_L : id_lat_i;
    rd_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - LW'(1);
    end
    if (issue && id_rd_we_i && (id_rd_i != '0)) begin
      rd_dec           = cnt_d[id_rd_i];
      cnt_d[id_rd_i]   = (lat_c > rd_dec) ? lat_c : rd_dec;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_titan_hazard_scoreboard.sv
module tb_titan_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;
  localparam int MAX_LAT  = 4;
  localparam int FWD_WIN  = 1;
  localparam int LW = 3;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic                  id_valid_i;
  logic [NUM_SRC*AW-1:0] id_rs_i;
  logic [NUM_SRC-1:0]    id_rs_used_i;
  logic [AW-1:0]         id_rd_i;
  logic                  id_rd_we_i;
  logic [LW-1:0]         id_lat_i;
  logic                  id_trap_i;
  logic                  hz_stall_o, trap_stall_o, stall_o, flush_o, busy_o;
  logic [NUM_SRC-1:0]    fwd_en_o;

  titan_hazard_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT), .FWD_WIN(FWD_WIN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rs_used_i(id_rs_used_i),
    .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i), .id_lat_i(id_lat_i),
    .id_trap_i(id_trap_i),
    .hz_stall_o(hz_stall_o), .trap_stall_o(trap_stall_o), .stall_o(stall_o),
    .fwd_en_o(fwd_en_o), .flush_o(flush_o), .busy_o(busy_o)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs0, rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       we;
    logic [2:0] lat;
    logic       trap;
    logic       hz, ts, fl, busy;
    logic [1:0] fwd;
  } vec_t;

  int tests  = 0;
  int failed = 0;
  int now    = 0;

  // ---------------- reference model ----------------
  // Each register keeps the absolute cycle at which its result becomes
  // available; its count is simply the distance to that cycle.
  int ready [NUM_REGS];
  bit trap_active;
  int trap_end;     // cycle of the flush pulse; trap stall lasts through it
  logic m_hz, m_ts, m_fl, m_busy, m_issue, m_accept;
  logic [1:0] m_fwd;

  function automatic int mcnt(input int r);
    if (r == 0) return 0;
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
    trap_active = 1'b0;
    trap_end    = -1;
  endtask

  task automatic model_eval(input vec_t v);
    bit in_trap;
    int c;
    int rs [2];
    rs[0] = v.rs0; rs[1] = v.rs1;
    in_trap = trap_active && (now <= trap_end);
    m_fl    = trap_active && (now == trap_end);
    m_busy  = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) if (mcnt(r) > 0) m_busy = 1'b1;
    m_accept = !in_trap && v.valid && v.trap;
    m_hz  = 1'b0;
    m_fwd = '0;
    for (int k = 0; k < 2; k++) begin
      c = mcnt(rs[k]);
      if (v.valid && v.used[k] && rs[k] != 0 && c > FWD_WIN) m_hz = 1'b1;
      if (v.used[k] && rs[k] != 0 && c >= 1 && c <= FWD_WIN) m_fwd[k] = 1'b1;
    end
    m_ts = in_trap || m_accept;
    if (m_hz || m_ts) m_fwd = '0;
    m_issue = v.valid && !m_hz && !m_ts && !v.trap;
  endtask

  task automatic model_commit(input vec_t v);
    int lc, mx;
    if (m_issue && v.we && v.rd != 0) begin
      lc = (v.lat > MAX_LAT) ? MAX_LAT : int'(v.lat);
      if (now + 1 + lc > ready[v.rd]) ready[v.rd] = now + 1 + lc;
    end
    if (m_accept) begin
      mx = now + 1;
      for (int r = 1; r < NUM_REGS; r++) if (ready[r] > mx) mx = ready[r];
      trap_active = 1'b1;
      trap_end    = mx + 1;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, now, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [1:0] used, input logic [4:0] rd, input logic we,
                              input logic [2:0] lat, input logic trap, input logic hz,
                              input logic ts, input logic fl, input logic busy,
                              input logic [1:0] fwd);
    vec_t v;
    v.valid = valid; v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.rd = rd; v.we = we;
    v.lat = lat; v.trap = trap; v.hz = hz; v.ts = ts; v.fl = fl; v.busy = busy; v.fwd = fwd;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge: drive, settle, compare, advance one cycle.
  task automatic step(input vec_t v, input bit use_tab);
    id_valid_i   = v.valid;
    id_rs_i      = {v.rs1, v.rs0};
    id_rs_used_i = v.used;
    id_rd_i      = v.rd;
    id_rd_we_i   = v.we;
    id_lat_i     = v.lat;
    id_trap_i    = v.trap;
    #1;
    model_eval(v);
    check("model_hz_stall",   {7'd0, hz_stall_o},   {7'd0, m_hz});
    check("model_trap_stall", {7'd0, trap_stall_o}, {7'd0, m_ts});
    check("model_stall",      {7'd0, stall_o},      {7'd0, m_hz | m_ts});
    check("model_flush",      {7'd0, flush_o},      {7'd0, m_fl});
    check("model_busy",       {7'd0, busy_o},       {7'd0, m_busy});
    check("model_fwd_en",     {6'd0, fwd_en_o},     {6'd0, m_fwd});
    if (use_tab) begin
      check("tab_hz_stall",   {7'd0, hz_stall_o},   {7'd0, v.hz});
      check("tab_trap_stall", {7'd0, trap_stall_o}, {7'd0, v.ts});
      check("tab_flush",      {7'd0, flush_o},      {7'd0, v.fl});
      check("tab_busy",       {7'd0, busy_o},       {7'd0, v.busy});
      check("tab_fwd_en",     {6'd0, fwd_en_o},     {6'd0, v.fwd});
    end
    model_commit(v);
    @(posedge clk_i);
    #1;
    now++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hz"},    {7'd0, hz_stall_o},   8'd0);
    check({tag, "_ts"},    {7'd0, trap_stall_o}, 8'd0);
    check({tag, "_stall"}, {7'd0, stall_o},      8'd0);
    check({tag, "_flush"}, {7'd0, flush_o},      8'd0);
    check({tag, "_busy"},  {7'd0, busy_o},       8'd0);
    check({tag, "_fwd"},   {6'd0, fwd_en_o},     8'd0);
  endtask

  vec_t tab [$];
  vec_t idle_v;

  initial begin
    //            vld rs0 rs1 used rd we lat trap | hz ts fl busy fwd
    // load x5 lat 3, consumer stalls twice then forwards
    tab.push_back(mk(1, 0, 0, 2'b00, 5, 1, 3, 0,  0, 0, 0, 0, 2'b00));
    tab.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0, 0,  0, 0, 0, 1, 2'b01));
    // x7 lat 1, back-to-back consumer forwards; port on x0 does not
    tab.push_back(mk(1, 0, 0, 2'b00, 7, 1, 1, 0,  0, 0, 0, 0, 2'b00));
    tab.push_back(mk(1, 7, 0, 2'b11, 0, 0, 0, 0,  0, 0, 0, 1, 2'b01));
    // WAW on x9: lat 4 then lat 1 keeps 3
    tab.push_back(mk(1, 0, 0, 2'b00, 9, 1, 4, 0,  0, 0, 0, 0, 2'b00));
    tab.push_back(mk(1, 0, 0, 2'b00, 9, 1, 1, 0,  0, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 9, 0, 2'b01, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 9, 0, 2'b01, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 9, 0, 2'b01, 0, 0, 0, 0,  0, 0, 0, 1, 2'b01));
    // latency 7 clamps to 4, checked on port 1
    tab.push_back(mk(1, 0, 0, 2'b00, 4, 1, 7, 0,  0, 0, 0, 0, 2'b00));
    tab.push_back(mk(1, 0, 4, 2'b10, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 0, 4, 2'b10, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 0, 4, 2'b10, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00));
    tab.push_back(mk(1, 0, 4, 2'b10, 0, 0, 0, 0,  0, 0, 0, 1, 2'b10));
    // trap with cnt[x3]=2: drain 2 cycles, single flush, back to idle
    tab.push_back(mk(1, 0, 0, 2'b00, 3, 1, 2, 0,  0, 0, 0, 0, 2'b00));
    tab.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 1,  0, 1, 0, 1, 2'b00));
    tab.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 1,  0, 1, 0, 1, 2'b00));
    tab.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0, 2'b00));
    tab.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 1, 0, 2'b00));
    tab.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00));
    idle_v = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00);

    // reset
    rst_ni = 1'b0;
    id_valid_i = 0; id_rs_i = '0; id_rs_used_i = '0; id_rd_i = '0;
    id_rd_we_i = 0; id_lat_i = '0; id_trap_i = 0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // directed table
    for (int i = 0; i < tab.size(); i++) step(tab[i], 1'b1);

    // reset asserted mid-DRAIN aborts the flush
    step(mk(1, 0, 0, 2'b00, 3, 1, 4, 0,  0, 0, 0, 0, 2'b00), 1'b1);
    step(mk(1, 0, 0, 2'b00, 0, 0, 0, 1,  0, 1, 0, 1, 2'b00), 1'b1);
    step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 1, 2'b00), 1'b1);
    rst_ni = 1'b0;
    #1;
    check_all_zero("mid_drain_reset");
    model_reset();
    @(posedge clk_i);
    #1;
    now++;
    rst_ni = 1'b1;
    step(mk(1, 0, 0, 2'b00, 5, 1, 2, 0,  0, 0, 0, 0, 2'b00), 1'b1);
    step(mk(1, 5, 0, 2'b01, 0, 0, 0, 0,  1, 0, 0, 1, 2'b00), 1'b1);
    for (int i = 0; i < 6; i++) step(idle_v, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      vec_t v;
      v = idle_v;
      v.valid = ($urandom_range(0, 3) != 0);
      v.rs0   = 5'($urandom_range(0, 6));
      v.rs1   = 5'($urandom_range(0, 6));
      v.used  = 2'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 6));
      v.we    = 1'($urandom_range(0, 1));
      v.lat   = 3'($urandom_range(0, 7));
      v.trap  = ($urandom_range(0, 24) == 0);
      step(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
